// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause 22 MDIO PHY-side responder with a 32x16 register file.
// MDC/MDIO are oversampled on clk; decoding advances on synchronised MDC rise events.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'b00001,
    parameter bit          BCAST_EN = 1'b0,
    parameter int          PRE_MIN  = 32,
    parameter logic [15:0] PHY_ID1  = 16'h0022,
    parameter logic [15:0] PHY_ID2  = 16'h1622
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdi,
    output logic        mdo,
    output logic        mdt,
    output logic        reg_wr_stb,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        frame_err
);
    typedef enum logic [2:0] {PRE, ST1, OP, PHYAD, REGAD, TA, DATA, SKIP} state_t;
    localparam logic [5:0] PMIN = 6'(PRE_MIN);

    state_t      state, state_nxt;
    logic [1:0]  mdc_s, mdi_s;
    logic        mdc_d, rise, fall, b;
    logic [5:0]  pcnt;
    logic [4:0]  pos, ra, regad, phyad;
    logic [10:0] sh;
    logic [15:0] wd, rdata;
    logic [15:0] regs [32];
    logic        rd_act, wr_act, err, commit, drive;

    assign rise  = mdc_s[1] & ~mdc_d;
    assign fall  = ~mdc_s[1] & mdc_d;
    assign b     = mdi_s[1];
    // pos is the index within the 32-bit frame (ST0 = 0) of the next bit to arrive
    assign phyad = sh[8:4];
    assign regad = {sh[3:0], b};
    assign drive = rd_act && (state == TA || state == DATA) && pos >= 5'd15;

    always_comb begin
        state_nxt = state;
        err = 1'b0;
        commit = 1'b0;
        if (rise) begin
            case (state)
                PRE:   state_nxt = (!b && pcnt >= PMIN) ? ST1 : PRE;
                ST1: begin
                    err = !b;
                    state_nxt = b ? OP : PRE;
                end
                OP: if (pos == 5'd3) begin
                    err = (sh[0] == b);
                    state_nxt = err ? SKIP : PHYAD;
                end
                PHYAD: state_nxt = (pos == 5'd8) ? REGAD : PHYAD;
                REGAD: state_nxt = (pos == 5'd13) ? TA : REGAD;
                TA: begin
                    err = wr_act && ((pos == 5'd14) ? !b : b);
                    state_nxt = err ? SKIP : (pos == 5'd15) ? DATA : TA;
                end
                DATA: begin
                    commit = (pos == 5'd31) && wr_act && (ra[4:1] != 4'b0001);
                    state_nxt = (pos == 5'd31) ? PRE : DATA;
                end
                default: state_nxt = (pos == 5'd31) ? PRE : SKIP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= PRE;
        else state <= state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdc_s <= '0;
            mdi_s <= '0;
            mdc_d <= 1'b0;
            pcnt <= '0;
            pos <= '0;
            sh <= '0;
            wd <= '0;
            ra <= '0;
            rdata <= '0;
            rd_act <= 1'b0;
            wr_act <= 1'b0;
            mdo <= 1'b1;
            mdt <= 1'b1;
            reg_wr_stb <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= (i == 2) ? PHY_ID1 : (i == 3) ? PHY_ID2 : '0;
        end else begin
            mdc_s <= {mdc_s[0], mdc};
            mdi_s <= {mdi_s[0], mdi};
            mdc_d <= mdc_s[1];
            frame_err <= err;
            reg_wr_stb <= commit;
            if (commit) begin
                regs[ra] <= {wd[14:0], b};
                reg_wr_addr <= ra;
                reg_wr_data <= {wd[14:0], b};
            end
            if (rise) begin
                pcnt <= (state != PRE || !b) ? 6'd0 : (pcnt == 6'd32) ? pcnt : pcnt + 6'd1;
                pos <= (state == PRE) ? 5'd1 : pos + 5'd1;
                sh <= {sh[9:0], b};
                wd <= {wd[14:0], b};
                if (state == REGAD && pos == 5'd13) begin
                    ra <= regad;
                    rdata <= regs[regad];
                    rd_act <= sh[10:9] == 2'b10 && phyad == PHY_ADDR;
                    wr_act <= sh[10:9] == 2'b01 && (phyad == PHY_ADDR || (BCAST_EN && phyad == 5'd0));
                end
            end
            if (fall) begin
                mdt <= !drive;
                mdo <= drive ? ((pos == 5'd15) ? 1'b0 : rdata[~pos[3:0]]) : 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder: drives Clause 22 frames into two responders (broadcast off/on)
// and checks strobes, errors, bus drive and read data against a register-array model.
module tb_mdio_phy_responder;
    localparam int HALF = 60;

    logic        clk, rst, mdc, m_oe, m_val;
    logic        mdi0, mdi1;
    logic        mdo [2];
    logic        mdt [2];
    logic        stb [2];
    logic        err [2];
    logic [4:0]  wa [2];
    logic [15:0] wdat [2];

    int          total, bad;
    int          n_stb [2];
    int          n_err [2];
    int          n_drv [2];
    logic [4:0]  la [2];
    logic [15:0] ld [2];
    logic [15:0] model [2][32];

    assign mdi0 = m_oe ? m_val : (mdt[0] | mdo[0]);
    assign mdi1 = m_oe ? m_val : (mdt[1] | mdo[1]);

    mdio_phy_responder dut0 (
        .clk(clk), .rst(rst), .mdc(mdc), .mdi(mdi0), .mdo(mdo[0]), .mdt(mdt[0]),
        .reg_wr_stb(stb[0]), .reg_wr_addr(wa[0]), .reg_wr_data(wdat[0]), .frame_err(err[0])
    );

    mdio_phy_responder #(.BCAST_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .mdc(mdc), .mdi(mdi1), .mdo(mdo[1]), .mdt(mdt[1]),
        .reg_wr_stb(stb[1]), .reg_wr_addr(wa[1]), .reg_wr_data(wdat[1]), .frame_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        for (int d = 0; d < 2; d++) begin
            if (stb[d]) begin
                n_stb[d]++;
                la[d] = wa[d];
                ld[d] = wdat[d];
            end
            if (err[d]) n_err[d]++;
        end

    always @(posedge mdc)
        for (int d = 0; d < 2; d++) if (!mdt[d]) n_drv[d]++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clock_bit(input logic v, input logic oe, output logic s0, output logic s1);
        m_oe = oe;
        m_val = v;
        #(HALF);
        mdc = 1'b1;
        s0 = mdi0;
        s1 = mdi1;
        #(HALF);
        mdc = 1'b0;
    endtask

    task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [1:0] ta, input logic [15:0] wd, input int abort_bit,
                         output logic [15:0] r0, output logic [15:0] r1, output logic t0, output logic t1);
        logic [31:0] f;
        logic        s0, s1, rd;
        rd = (op == 2'b10);
        f = {2'b01, op, phy, ra, ta, wd};
        r0 = '0;
        r1 = '0;
        t0 = 1'b1;
        t1 = 1'b1;
        for (int i = 0; i < npre; i++) clock_bit(1'b1, 1'b1, s0, s1);
        for (int i = 0; i < 32; i++) begin
            if (i == abort_bit) return;
            clock_bit(f[31-i], !(rd && i >= 14), s0, s1);
            if (i == 15) begin
                t0 = s0;
                t1 = s1;
            end
            if (i >= 16) begin
                r0 = {r0[14:0], s0};
                r1 = {r1[14:0], s1};
            end
        end
        m_oe = 1'b1;
        m_val = 1'b1;
    endtask

    function automatic logic [15:0] exp_read(input int d, input logic [4:0] ra);
        return (ra == 5'd2) ? 16'h0022 : (ra == 5'd3) ? 16'h1622 : model[d][ra];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) model[d][i] = '0;
    endtask

    task automatic run(input int npre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [1:0] ta, input logic [15:0] wd);
        logic [15:0] r [2];
        logic        t [2];
        for (int d = 0; d < 2; d++) begin
            n_stb[d] = 0;
            n_err[d] = 0;
            n_drv[d] = 0;
        end
        frame(npre, op, phy, ra, ta, wd, 99, r[0], r[1], t[0], t[1]);
        repeat (8) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit ok_pre = (npre >= 32);
            bit rdm = ok_pre && op == 2'b10 && phy == 5'd1;
            bit wrm = ok_pre && op == 2'b01 && (phy == 5'd1 || (d == 1 && phy == 5'd0));
            bit er = ok_pre && (op == 2'b00 || op == 2'b11 || (wrm && ta != 2'b10));
            bit st = wrm && ta == 2'b10 && ra != 5'd2 && ra != 5'd3;
            chk($sformatf("stb_cnt d%0d", d), n_stb[d], st ? 1 : 0);
            if (st) begin
                chk($sformatf("wr_addr d%0d", d), la[d], ra);
                chk($sformatf("wr_data d%0d", d), ld[d], wd);
                model[d][ra] = wd;
            end
            chk($sformatf("err_cnt d%0d", d), n_err[d], er ? 1 : 0);
            chk($sformatf("drive_len d%0d", d), n_drv[d], rdm ? 17 : 0);
            if (rdm) begin
                chk($sformatf("ta0 d%0d", d), t[d], 1'b0);
                chk($sformatf("rdata d%0d r%0d", d, ra), r[d], exp_read(d, ra));
            end
            chk($sformatf("mdt_idle d%0d", d), mdt[d], 1'b1);
            chk($sformatf("mdo_idle d%0d", d), mdo[d], 1'b1);
        end
    endtask

    initial begin
        logic [15:0] r0, r1;
        logic        t0, t1;
        total = 0;
        bad = 0;
        rst = 1'b1;
        mdc = 1'b0;
        m_oe = 1'b1;
        m_val = 1'b1;
        for (int d = 0; d < 2; d++) begin
            n_stb[d] = 0;
            n_err[d] = 0;
            n_drv[d] = 0;
        end
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_mdo", mdo[d], 1'b1);
            chk("rst_mdt", mdt[d], 1'b1);
            chk("rst_stb", stb[d], 1'b0);
            chk("rst_addr", wa[d], 5'd0);
            chk("rst_data", wdat[d], 16'd0);
            chk("rst_err", err[d], 1'b0);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);

        run(32, 2'b01, 5'd1, 5'h10, 2'b10, 16'hA5C3);
        run(32, 2'b10, 5'd1, 5'h10, 2'b10, 16'h0000);
        run(32, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0000);
        run(32, 2'b10, 5'd1, 5'd3, 2'b10, 16'h0000);
        run(32, 2'b01, 5'd1, 5'd2, 2'b10, 16'hFFFF);
        run(32, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0000);
        run(32, 2'b10, 5'd2, 5'h10, 2'b10, 16'h0000);
        run(32, 2'b01, 5'd2, 5'h10, 2'b10, 16'h1111);
        run(32, 2'b01, 5'd0, 5'd5, 2'b10, 16'h1234);
        run(32, 2'b10, 5'd0, 5'd5, 2'b10, 16'h0000);
        run(31, 2'b01, 5'd1, 5'd7, 2'b10, 16'hBEEF);
        run(32, 2'b10, 5'd1, 5'd7, 2'b10, 16'h0000);
        run(32, 2'b11, 5'd1, 5'd4, 2'b10, 16'h5555);
        run(32, 2'b00, 5'd1, 5'd4, 2'b10, 16'h5555);
        run(32, 2'b01, 5'd1, 5'h10, 2'b00, 16'h0F0F);
        run(32, 2'b10, 5'd1, 5'h10, 2'b10, 16'h0000);

        frame(32, 2'b10, 5'd1, 5'h10, 2'b10, 16'h0000, 23, r0, r1, t0, t1);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_mdt", mdt[0], 1'b0);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_mdt", mdt[d], 1'b1);
            chk("midrst_mdo", mdo[d], 1'b1);
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_oe = 1'b1;
        m_val = 1'b1;
        repeat (3) @(posedge clk);
        run(32, 2'b10, 5'd1, 5'h10, 2'b10, 16'h0000);
        run(32, 2'b01, 5'd1, 5'd9, 2'b10, 16'hC0DE);
        run(32, 2'b10, 5'd1, 5'd9, 2'b10, 16'h0000);

        for (int k = 0; k < 30; k++) begin
            int          sel;
            logic [1:0]  op, ta;
            logic [4:0]  phy, ra;
            logic [15:0] dat;
            sel = $urandom_range(0, 9);
            op = (sel < 4) ? 2'b01 : (sel < 8) ? 2'b10 : (sel == 8) ? 2'b00 : 2'b11;
            phy = 5'($urandom_range(0, 2));
            ra = 5'($urandom_range(0, 7));
            ta = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            dat = 16'($urandom);
            run(32, op, phy, ra, ta, dat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- Clause 22 MDIO responder modelling the PHY end of the management interface driven by the team's MDIO master (the block that programs PHY RX clock delays).
- Oversamples MDC/MDIO with the system clock, decodes read and write frames addressed to its PHY address, and returns register data on reads.
- Keeps a 32x16 register file and reports every accepted write to local logic.
- Used as a PHY stand-in on FPGA loopback boards and as the reference responder in master benches.

Parameters:
- PHY_ADDR, 5'b00001, PHY address this responder answers to.
- BCAST_EN, 0, 1 = also accept writes (never reads) addressed to PHY address 0.
- PRE_MIN, 32, consecutive 1 bits (sampled on MDC rising edges) required before ST is recognised; legal range 1..32.
- PHY_ID1, 16'h0022, read-only value of register 2.
- PHY_ID2, 16'h1622, read-only value of register 3.

Ports:
- clk, in, 1, system clock; MDC high and low phases must each be at least 4 clk periods.
- rst, in, 1, asynchronous active-high reset.
- mdc, in, 1, management clock from the master, asynchronous to clk.
- mdi, in, 1, MDIO line value seen at the pad, asynchronous to clk.
- mdo, out, 1, MDIO output value.
- mdt, out, 1, MDIO tristate control: 1 = released (high-Z), 0 = driving mdo.
- reg_wr_stb, out, 1, one-clk pulse per accepted write.
- reg_wr_addr, out, 5, register address of the last accepted write.
- reg_wr_data, out, 16, data of the last accepted write.
- frame_err, out, 1, one-clk pulse when a frame is rejected.

Behaviour:
- Reset values: mdo=1, mdt=1, reg_wr_stb=0, reg_wr_addr=0, reg_wr_data=0, frame_err=0. The register file resets to 0 except regs 2 and 3 (PHY_ID1, PHY_ID2). State returns to PRE and the preamble count clears.
- Reset asserted mid-frame releases mdt on the next clk edge or asynchronously; no write commits.
- Input sampling: mdc and mdi each pass through a 2-FF synchroniser. A rise or fall of synchronised MDC is a one-clk event.
- mdi is sampled at the rise event. mdo/mdt update only at the fall event.
- Pad-to-pad response latency is at most 4 clk after the MDC falling edge.
- State machine (advances on rise events):
  - PRE: count consecutive 1s, saturating at 32; a 0 clears the count. A 0 with count >= PRE_MIN goes to ST1.
  - ST1: the bit must be 1, then go to OP. A 0 here is a frame error: pulse frame_err and return to PRE.
  - OP: 2 bits. 10 = read, 01 = write. 00 or 11: pulse frame_err, go to SKIP.
  - PHYAD: 5 bits, MSB first.
  - REGAD: 5 bits, MSB first.
  - TA: 2 bits.
  - DATA: 16 bits, MSB first.
  - SKIP: consume the remaining bits of a standard 64-bit frame without driving the line, then go to PRE.
- Address match: read requires PHYAD==PHY_ADDR. Write requires PHYAD==PHY_ADDR, or PHYAD==0 when BCAST_EN=1.
- Non-matching frames: still walk TA/DATA (bit counting only) with mdt=1, then go to PRE. No strobe, no error.
- Read, matched:
  - Latch regfile[REGAD] at the last REGAD rise event.
  - First TA bit: stay released.
  - At the fall event after the first TA rise: mdt=0, mdo=0.
  - At each following fall event: shift out the next data bit, MSB first.
  - At the fall event after the 16th data rise: mdt=1, mdo=1.
  - Total drive window is 17 MDC periods.
- Write, matched:
  - TA must sample 1 then 0. Otherwise pulse frame_err, discard the frame and go to SKIP.
  - After the 16th data rise event, write regfile[REGAD] and pulse reg_wr_stb for 1 clk with reg_wr_addr/reg_wr_data updated on the same cycle.
  - Writes to regs 2 and 3 are discarded: no regfile change, no strobe, no error.
- After every frame the preamble count restarts at 0, so a new full preamble is required.
- A rise and a fall event never occur in the same clk, given the MDC phase constraint above.

Test Plan:
- Write to PHY 1 (32 ones, 01 01 00001 10000 10 A5C3) -> exactly one reg_wr_stb pulse with addr=0x10, data=0xA5C3; mdt stays 1 for the whole frame.
- Read PHY 1 reg 0x10 after the write -> mdt=0 from the TA second bit for 17 MDC periods; master samples TA0=0 then 0xA5C3; mdt=1 afterwards.
- Read reg 2 and reg 3 -> 0x0022 and 0x1622. Then write 0xFFFF to reg 2 -> no strobe, and a read-back still returns 0x0022.
- Read and write to PHY 2 -> mdt never 0, no strobe, no frame_err. Repeat with BCAST_EN=1: a write to PHY 0 strobes, a read from PHY 0 is ignored.
- Frame with only 31 preamble ones -> frame ignored, no strobe, no drive. Op 11 -> one frame_err pulse. Write with TA=00 -> frame_err, register unchanged.
- Assert rst during the 8th data bit of a read -> mdt=1, mdo=1 immediately. After release, the next full frame is decoded correctly.
